// File: rtl/bus_pkt_dispatch_if.sv
// bus_pkt_dispatch_if: host beat stream in, per-channel turbo beat strobes out, plus statistics.
interface bus_pkt_dispatch_if #(
    parameter int BUS    = 534,
    parameter int NUM_CH = 4,
    parameter int CHW    = 4
);
    logic [BUS-1:0]    bus_data;
    logic              bus_en;
    logic              bus_ready;
    logic [BUS-1:0]    ch_data;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] ch_ready;
    logic [CHW-1:0]    cur_ch;
    logic              pkt_done;
    logic [31:0]       pkt_count;
    logic [15:0]       drop_count;

    modport master (
        output bus_data, bus_en, ch_ready,
        input  bus_ready, ch_data, ch_en, cur_ch, pkt_done, pkt_count, drop_count
    );
    modport slave (
        input  bus_data, bus_en, ch_ready,
        output bus_ready, ch_data, ch_en, cur_ch, pkt_done, pkt_count, drop_count
    );
endinterface

// File: rtl/bus_pkt_dispatch.sv
// bus_pkt_dispatch: cuts the bus beat stream into fixed-length packets and steers each whole
// packet round-robin (optionally skipping busy channels) to one of NUM_CH channels.
module bus_pkt_dispatch #(
    parameter int BUS           = 534,
    parameter int NUM_CH        = 4,
    parameter int BEATS_PER_PKT = 25,
    parameter bit SKIP_BUSY     = 1'b1,
    parameter int CHW           = 4
) (
    input logic clk_bus,
    input logic rst_n,
    bus_pkt_dispatch_if.slave io
);
    localparam int CW = $clog2(BEATS_PER_PKT);

    typedef enum logic {SELECT, XFER} state_t;

    state_t            state;
    logic [CHW-1:0]    ptr, pick, nxt_cur;
    logic [CW-1:0]     cnt;
    logic              found, last, nxt_xfer;
    logic [NUM_CH-1:0] rdy_sh, nxt_rdy;
    int                j;

    // Scan from ptr in RR order; strict mode only looks at ptr itself.
    always_comb begin
        found  = 1'b0;
        pick   = ptr;
        j      = 0;
        rdy_sh = '0;
        for (int i = 0; i < (SKIP_BUSY ? NUM_CH : 1); i++) begin
            j      = int'(ptr) + i;
            j      = j >= NUM_CH ? j - NUM_CH : j;
            rdy_sh = io.ch_ready >> j;
            if (!found && rdy_sh[0]) begin
                found = 1'b1;
                pick  = CHW'(j);
            end
        end
    end

    assign last     = cnt == CW'(BEATS_PER_PKT - 1);
    assign nxt_xfer = state == SELECT ? found : !(io.bus_en && last);
    assign nxt_cur  = (state == SELECT && found) ? pick : io.cur_ch;
    assign nxt_rdy  = io.ch_ready >> nxt_cur;

    always_ff @(posedge clk_bus) begin
        if (!rst_n) begin
            state         <= SELECT;
            ptr           <= '0;
            cnt           <= '0;
            io.cur_ch     <= '0;
            io.bus_ready  <= 1'b0;
            io.ch_en      <= '0;
            io.pkt_done   <= 1'b0;
            io.ch_data    <= '0;
            io.pkt_count  <= '0;
            io.drop_count <= '0;
        end else begin
            io.ch_en     <= '0;
            io.pkt_done  <= 1'b0;
            io.bus_ready <= nxt_xfer && nxt_rdy[0];
            io.cur_ch    <= nxt_cur;
            if (state == SELECT) begin
                if (io.bus_en && io.drop_count != 16'hFFFF)
                    io.drop_count <= io.drop_count + 16'd1;
                if (found)
                    state <= XFER;
            end else if (io.bus_en) begin
                io.ch_data <= io.bus_data;
                io.ch_en   <= NUM_CH'(1) << io.cur_ch;
                cnt        <= last ? '0 : cnt + 1'b1;
                if (last) begin
                    io.pkt_done  <= 1'b1;
                    io.pkt_count <= io.pkt_count + 32'd1;
                    ptr          <= io.cur_ch == CHW'(NUM_CH - 1) ? '0 : io.cur_ch + 1'b1;
                    state        <= SELECT;
                end
            end
        end
    end
endmodule

// File: tb/tb_bus_pkt_dispatch.sv
// tb_bus_pkt_dispatch: two configurations driven with random beats, checked every cycle
// against a packet-level reference model.
module tb_bus_pkt_dispatch;
    localparam int BUS = 48;
    localparam int CHW = 4;
    localparam int NCH [2] = '{4, 3};
    localparam int SKP [2] = '{1, 0};
    localparam int BPP [2] = '{25, 2};

    logic clk_bus = 1'b0;
    logic rst_n   = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;

    always #5 clk_bus = ~clk_bus;

    bus_pkt_dispatch_if #(.BUS(BUS), .NUM_CH(4), .CHW(CHW)) a ();
    bus_pkt_dispatch_if #(.BUS(BUS), .NUM_CH(3), .CHW(CHW)) b ();

    bus_pkt_dispatch #(.BUS(BUS), .NUM_CH(4), .BEATS_PER_PKT(25), .SKIP_BUSY(1'b1), .CHW(CHW))
        u_a (.clk_bus(clk_bus), .rst_n(rst_n), .io(a.slave));
    bus_pkt_dispatch #(.BUS(BUS), .NUM_CH(3), .BEATS_PER_PKT(2), .SKIP_BUSY(1'b0), .CHW(CHW))
        u_b (.clk_bus(clk_bus), .rst_n(rst_n), .io(b.slave));

    // Model: selecting flag, RR pointer, owning channel, beats still owed to the packet.
    bit             m_sel  [2];
    int             m_ptr  [2];
    int             m_cur  [2];
    int             m_left [2];
    logic [15:0]    e_en   [2];
    logic [BUS-1:0] e_data [2];
    bit             e_done [2];
    bit             e_rdy  [2];
    int             e_pc   [2];
    int             e_dc   [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int u, input bit rs, input bit en, input logic [BUS-1:0] d,
                        input logic [15:0] rdy);
        if (!rs) begin
            m_sel[u] = 1; m_ptr[u] = 0; m_cur[u] = 0; m_left[u] = 0;
            e_en[u] = '0; e_data[u] = '0; e_done[u] = 0; e_rdy[u] = 0;
            e_pc[u] = 0; e_dc[u] = 0;
            return;
        end
        e_en[u]   = '0;
        e_done[u] = 0;
        if (m_sel[u]) begin
            if (en && e_dc[u] < 65535) e_dc[u]++;
            for (int k = 0; k < (SKP[u] != 0 ? NCH[u] : 1); k++) begin
                int c = (m_ptr[u] + k) % NCH[u];
                if (m_sel[u] && rdy[c]) begin
                    m_cur[u] = c; m_sel[u] = 0; m_left[u] = BPP[u];
                end
            end
        end else if (en) begin
            e_data[u] = d;
            e_en[u]   = 16'(1) << m_cur[u];
            m_left[u]--;
            if (m_left[u] == 0) begin
                e_done[u] = 1; e_pc[u]++;
                m_ptr[u] = (m_cur[u] + 1) % NCH[u];
                m_sel[u] = 1;
            end
        end
        e_rdy[u] = !m_sel[u] && rdy[m_cur[u]];
    endtask

    task automatic check_all();
        chk("a.bus_ready", 64'(a.bus_ready), 64'(e_rdy[0]));
        chk("a.ch_en", 64'(a.ch_en), 64'(e_en[0]));
        chk("a.ch_data", 64'(a.ch_data), 64'(e_data[0]));
        chk("a.pkt_done", 64'(a.pkt_done), 64'(e_done[0]));
        chk("a.cur_ch", 64'(a.cur_ch), 64'(m_cur[0]));
        chk("a.pkt_count", 64'(a.pkt_count), 64'(e_pc[0]));
        chk("a.drop_count", 64'(a.drop_count), 64'(e_dc[0]));
        chk("b.bus_ready", 64'(b.bus_ready), 64'(e_rdy[1]));
        chk("b.ch_en", 64'(b.ch_en), 64'(e_en[1]));
        chk("b.ch_data", 64'(b.ch_data), 64'(e_data[1]));
        chk("b.pkt_done", 64'(b.pkt_done), 64'(e_done[1]));
        chk("b.cur_ch", 64'(b.cur_ch), 64'(m_cur[1]));
        chk("b.pkt_count", 64'(b.pkt_count), 64'(e_pc[1]));
        chk("b.drop_count", 64'(b.drop_count), 64'(e_dc[1]));
    endtask

    task automatic cycle(input bit rs, input bit en, input logic [15:0] ra, input logic [15:0] rb);
        logic [63:0]    r = {$urandom, $urandom};
        logic [BUS-1:0] d = r[BUS-1:0];
        rst_n      = rs;
        a.bus_en   = en;   b.bus_en   = en;
        a.bus_data = d;    b.bus_data = d;
        a.ch_ready = ra[3:0];
        b.ch_ready = rb[2:0];
        step(0, rs, en, d, ra);
        step(1, rs, en, d, rb);
        @(posedge clk_bus);
        @(negedge clk_bus);
        check_all();
    endtask

    initial begin
        logic [15:0] ra = 16'hF;
        logic [15:0] rb = 16'h7;
        @(negedge clk_bus);
        repeat (3) cycle(1'b0, 1'b0, ra, rb);
        // All channels ready, continuous beats: plain round-robin.
        repeat (4 * 27) cycle(1'b1, 1'b1, ra, rb);
        chk("a.pkts_after_burst", 64'(a.pkt_count), 64'(4));
        // Channel 2 busy with ptr at 0: exercises skip-over.
        ra = 16'b1011;
        repeat (120) cycle(1'b1, 1'b1, ra, rb);
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(15) == 0) ra = $urandom_range(1) != 0 ? 16'hF : 16'($urandom_range(15));
            if ($urandom_range(15) == 0) rb = $urandom_range(1) != 0 ? 16'h7 : 16'($urandom_range(7));
            cycle($urandom_range(299) != 0, $urandom_range(3) != 0, ra, rb);
        end
        // Reset mid-packet, then restart with all ready.
        ra = 16'hF; rb = 16'h7;
        repeat (12) cycle(1'b1, 1'b1, ra, rb);
        cycle(1'b0, 1'b1, ra, rb);
        chk("a.cur_after_rst", 64'(a.cur_ch), 64'(0));
        repeat (30) cycle(1'b1, 1'b1, ra, rb);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
